sync_fifo_flags: RTL

Parametrised single-clock FIFO with simultaneous read/write, programmable almost-full/almost-empty thresholds, occupancy count and sticky overflow/underflow error flags. It is the general-purpose buffer between producer and consumer blocks in the same clock domain. It replaces fixed 8x16 buffering wherever width, depth or early back-pressure must be tuned.

---
 rtl/sync_fifo_flags.sv | 99 +++++++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with count, threshold flags and sticky errors; FIFO_FWFT_EN selects first-word-fall-through
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc, rd_acc;

  // Acceptance is judged on the registered count, so a full FIFO still pops but never takes the write.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (wr_en & full);
    udf_d    = udf_q | (rd_en & empty);
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (rd_acc) data_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge CLK) begin
    if (RST) data_q <= '0;
    else     data_q <= data_d;
  end

  assign data_out = data_q;
`endif

  assign count        = count_q;
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
endmodule
